l15_msg_arbiter: RTL and testbench

L15_MSG_ARBITER -- requirements
Module: l15_msg_arbiter

---
 rtl/l15_msg_arbiter.sv | 157 +++++++++++++++
 tb/tb_l15_msg_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l15_msg_arbiter.sv
// L1.5 message arbiter: merges four core request ports and one memory-response
// port into a single registered output slot feeding the L2.
//
// state  | meaning
// -------+-----------------------------------------------------------
// EMPTY  | output slot holds no message; out_valid=0, any requester may load
// FULL   | output slot holds a message; reloads only when out_ready=1

`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 0
`endif

module l15_msg_arbiter #(
    parameter int MSG_W  = `MSG_WIDTH,
    parameter int DATA_W = `DATA_WIDTH,
    parameter int TAG_W  = `TAG_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*MSG_W-1:0]  req_type,
    input  logic [4*DATA_W-1:0] req_data,
    input  logic [4*TAG_W-1:0]  req_tag,
    output logic [3:0]          req_ack,
    input  logic [MSG_W-1:0]    mem_type,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic [TAG_W-1:0]    mem_tag,
    output logic                mem_ack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MSG_W-1:0]    out_type,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic [1:0]          out_source,
    output logic                out_from_mem
);

    localparam logic [MSG_W-1:0] TYPE_EMPTY = MSG_W'(`MSG_TYPE_EMPTY);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t state;
    logic [1:0] pointer;

    logic [3:0]        core_req;
    logic              mem_req;
    logic              core_win;
    logic [1:0]        win_idx;
    logic              load_en;
    logic              grant;
    logic [MSG_W-1:0]  sel_type;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_tag;

    // Round-robin scan starting at ptr; the lowest offset that requests wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, ptr};
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        core_req = '0;
        for (int i = 0; i < 4; i++) begin
            core_req[i] = (req_type[i*MSG_W +: MSG_W] != TYPE_EMPTY);
        end
    end

    assign mem_req             = (mem_type != TYPE_EMPTY);
    assign {core_win, win_idx} = rr_pick(core_req, pointer);

    // In EMPTY the slot is free regardless of out_ready.
    assign load_en = (state == S_EMPTY) | out_ready;
    assign grant   = rst & load_en;

    always_comb begin
        mem_ack = 1'b0;
        req_ack = 4'b0000;
        if (grant) begin
            if (mem_req) begin
                mem_ack = 1'b1;
            end else if (core_win) begin
                req_ack = 4'b0001 << win_idx;
            end
        end
    end

    always_comb begin
        sel_type = req_type[win_idx*MSG_W +: MSG_W];
        sel_data = req_data[win_idx*DATA_W +: DATA_W];
        sel_tag  = req_tag[win_idx*TAG_W +: TAG_W];
        if (mem_req) begin
            sel_type = mem_type;
            sel_data = mem_data;
            sel_tag  = mem_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_EMPTY;
            out_valid    <= 1'b0;
            out_type     <= TYPE_EMPTY;
            out_data     <= '0;
            out_tag      <= '0;
            out_source   <= 2'd0;
            out_from_mem <= 1'b0;
            pointer      <= 2'd0;
        end else if (load_en) begin
            if (mem_req) begin
                state        <= S_FULL;
                out_valid    <= 1'b1;
                out_type     <= sel_type;
                out_data     <= sel_data;
                out_tag      <= sel_tag;
                out_source   <= 2'd0;
                out_from_mem <= 1'b1;
            end else if (core_win) begin
                state        <= S_FULL;
                out_valid    <= 1'b1;
                out_type     <= sel_type;
                out_data     <= sel_data;
                out_tag      <= sel_tag;
                out_source   <= win_idx;
                out_from_mem <= 1'b0;
                pointer      <= win_idx + 2'd1;
            end else begin
                state        <= S_EMPTY;
                out_valid    <= 1'b0;
                out_type     <= TYPE_EMPTY;
                out_data     <= '0;
                out_tag      <= '0;
                out_source   <= 2'd0;
                out_from_mem <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l15_msg_arbiter.sv
// Bench for l15_msg_arbiter: table of per-cycle vectors with expected acks and
// pointer, expected output messages queued at drive time and checked after the edge.

module tb_l15_msg_arbiter;

    localparam int MW = 8;
    localparam int DW = 16;
    localparam int TW = 4;

    localparam int K_CAP   = 0;
    localparam int K_HOLD  = 1;
    localparam int K_EMPTY = 2;
    localparam int K_RESET = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4*MW-1:0] req_type = '0;
    logic [4*DW-1:0] req_data = '0;
    logic [4*TW-1:0] req_tag  = '0;
    logic [3:0]      req_ack;
    logic [MW-1:0]   mem_type = '0;
    logic [DW-1:0]   mem_data = '0;
    logic [TW-1:0]   mem_tag  = '0;
    logic            mem_ack;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [MW-1:0]   out_type;
    logic [DW-1:0]   out_data;
    logic [TW-1:0]   out_tag;
    logic [1:0]      out_source;
    logic            out_from_mem;

    always #5 clk = ~clk;

    l15_msg_arbiter #(.MSG_W(MW), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_type     (req_type),
        .req_data     (req_data),
        .req_tag      (req_tag),
        .req_ack      (req_ack),
        .mem_type     (mem_type),
        .mem_data     (mem_data),
        .mem_tag      (mem_tag),
        .mem_ack      (mem_ack),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_type     (out_type),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_source   (out_source),
        .out_from_mem (out_from_mem)
    );

    typedef struct packed {
        logic          valid;
        logic [MW-1:0] typ;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic [1:0]    src;
        logic          from_mem;
    } msg_t;

    typedef struct {
        logic       rst_n;
        logic       rdy;
        logic [3:0] cores;
        logic       mem;
        logic [4:0] ack;
        int         kind;
        logic [1:0] ptr;
    } vec_t;

    msg_t sb[$];
    msg_t last_exp = '0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [MW-1:0] cur_type[4];
    logic [DW-1:0] cur_data[4];
    logic [TW-1:0] cur_tag[4];
    logic [MW-1:0] cur_mtype;
    logic [DW-1:0] cur_mdata;
    logic [TW-1:0] cur_mtag;

    vec_t tbl[24];

    task automatic step(input string name, input logic rst_n, input logic rdy,
                        input logic [3:0] cores, input logic mem,
                        input logic [4:0] exp_ack, input int kind,
                        input logic [1:0] exp_ptr);
        msg_t e;
        msg_t got;
        logic [4:0] ack;
        @(negedge clk);
        rst       = rst_n;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            req_type[i*MW +: MW] = cores[i] ? cur_type[i] : '0;
            req_data[i*DW +: DW] = cur_data[i];
            req_tag[i*TW +: TW]  = cur_tag[i];
        end
        mem_type = mem ? cur_mtype : '0;
        mem_data = cur_mdata;
        mem_tag  = cur_mtag;
        #2;
        ack = {mem_ack, req_ack};
        n_tests++;
        if (ack !== exp_ack) begin
            n_fail++;
            $display("FAIL %s ack: got %b want %b", name, ack, exp_ack);
        end
        e = '0;
        if (kind == K_CAP) begin
            if (exp_ack[4]) begin
                e = {1'b1, cur_mtype, cur_mdata, cur_mtag, 2'd0, 1'b0};
                e.from_mem = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (exp_ack[i]) e = {1'b1, cur_type[i], cur_data[i], cur_tag[i], 2'(i), 1'b0};
                end
            end
        end else if (kind == K_HOLD) begin
            e = last_exp;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {out_valid, out_type, out_data, out_tag, out_source, out_from_mem};
        e = sb.pop_front();
        n_tests++;
        if (kind == K_EMPTY) begin
            if (got.valid !== 1'b0 || got.typ !== '0) begin
                n_fail++;
                $display("FAIL %s empty: got valid=%b type=%h want valid=0 type=00",
                         name, got.valid, got.typ);
            end
        end else if (got !== e) begin
            n_fail++;
            $display("FAIL %s out: got v=%b t=%h d=%h g=%h s=%0d m=%b want v=%b t=%h d=%h g=%h s=%0d m=%b",
                     name, got.valid, got.typ, got.data, got.tag, got.src, got.from_mem,
                     e.valid, e.typ, e.data, e.tag, e.src, e.from_mem);
        end
        last_exp = e;
        n_tests++;
        if (dut.pointer !== exp_ptr) begin
            n_fail++;
            $display("FAIL %s pointer: got %0d want %0d", name, dut.pointer, exp_ptr);
        end
    endtask

    task automatic set_vals(input int v);
        for (int i = 0; i < 4; i++) begin
            cur_type[i] = MW'(8'h20 + v*4 + i);
            cur_data[i] = DW'(v*256 + i*16 + 5);
            cur_tag[i]  = TW'(v + i + 1);
        end
        cur_mtype = 8'hF0;
        cur_mdata = 16'hBEEF ^ DW'(v);
        cur_mtag  = 4'hC;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //               rst rdy cores    mem ack       kind     ptr
        tbl[0]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 5'b00000, K_EMPTY, 2'd3};
        tbl[1]  = '{1'b0, 1'b1, 4'b1111, 1'b0, 5'b00000, K_RESET, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 5'b00001, K_CAP,   2'd1};
        tbl[3]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 5'b00010, K_CAP,   2'd2};
        tbl[4]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 5'b00100, K_CAP,   2'd3};
        tbl[5]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 5'b01000, K_CAP,   2'd0};
        tbl[6]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 5'b00001, K_CAP,   2'd1};
        tbl[7]  = '{1'b1, 1'b1, 4'b1010, 1'b1, 5'b10000, K_CAP,   2'd1};
        tbl[8]  = '{1'b1, 1'b1, 4'b1010, 1'b0, 5'b00010, K_CAP,   2'd2};
        tbl[9]  = '{1'b1, 1'b1, 4'b1000, 1'b0, 5'b01000, K_CAP,   2'd0};
        tbl[10] = '{1'b1, 1'b1, 4'b0000, 1'b0, 5'b00000, K_EMPTY, 2'd0};
        tbl[11] = '{1'b1, 1'b1, 4'b0001, 1'b0, 5'b00001, K_CAP,   2'd1};
        tbl[12] = '{1'b1, 1'b0, 4'b0100, 1'b0, 5'b00000, K_HOLD,  2'd1};
        tbl[13] = '{1'b1, 1'b0, 4'b0100, 1'b0, 5'b00000, K_HOLD,  2'd1};
        tbl[14] = '{1'b1, 1'b0, 4'b0100, 1'b0, 5'b00000, K_HOLD,  2'd1};
        tbl[15] = '{1'b1, 1'b1, 4'b0100, 1'b0, 5'b00100, K_CAP,   2'd3};
        tbl[16] = '{1'b0, 1'b1, 4'b0010, 1'b0, 5'b00000, K_RESET, 2'd0};
        tbl[17] = '{1'b1, 1'b0, 4'b0010, 1'b0, 5'b00010, K_CAP,   2'd2};
        tbl[18] = '{1'b1, 1'b0, 4'b0000, 1'b0, 5'b00000, K_HOLD,  2'd2};
        tbl[19] = '{1'b1, 1'b1, 4'b0000, 1'b0, 5'b00000, K_EMPTY, 2'd2};
        tbl[20] = '{1'b1, 1'b0, 4'b0000, 1'b0, 5'b00000, K_EMPTY, 2'd2};
        tbl[21] = '{1'b1, 1'b0, 4'b1001, 1'b1, 5'b10000, K_CAP,   2'd2};
        tbl[22] = '{1'b1, 1'b1, 4'b1001, 1'b0, 5'b01000, K_CAP,   2'd0};
        tbl[23] = '{1'b1, 1'b1, 4'b0001, 1'b0, 5'b00001, K_CAP,   2'd1};

        set_vals(99);
        step("reset0", 1'b0, 1'b1, 4'b0000, 1'b0, 5'b00000, K_RESET, 2'd0);
        step("reset1", 1'b0, 1'b1, 4'b1111, 1'b1, 5'b00000, K_RESET, 2'd0);

        // Lone core 2 request with fixed tag/data, checked field by field.
        set_vals(98);
        cur_type[2] = 8'h21;
        cur_tag[2]  = 4'd5;
        cur_data[2] = 16'h000A;
        step("core2_only", 1'b1, 1'b1, 4'b0100, 1'b0, 5'b00100, K_CAP, 2'd3);
        n_tests++;
        if (out_source !== 2'd2 || out_tag !== 4'd5 || out_data !== 16'h000A || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL core2_fields: got v=%b s=%0d tag=%0d data=%h want v=1 s=2 tag=5 data=000a",
                     out_valid, out_source, out_tag, out_data);
        end

        for (int v = 0; v < 24; v++) begin
            set_vals(v);
            step($sformatf("vec%0d", v), tbl[v].rst_n, tbl[v].rdy, tbl[v].cores,
                 tbl[v].mem, tbl[v].ack, tbl[v].kind, tbl[v].ptr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
